load_store_unit: RTL



---
 rtl/load_store_unit_pkg.sv | 21 ++
 rtl/load_store_unit_if.sv | 21 ++
 rtl/load_store_unit_port_in_sync.sv | 25 ++
 rtl/load_store_unit.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared state encoding and address-map defaults for the load/store unit
package load_store_unit_pkg;

  // Transaction sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_t;

  // Default memory map
  localparam logic [31:0] DEF_DATA_BASE      = 32'h1001_0000;
  localparam int          DEF_DATA_DEPTH     = 64;
  localparam logic [31:0] DEF_PORT_OUT_ADDR  = 32'h1001_0100;
  localparam logic [31:0] DEF_PORT_IN_ADDR   = 32'h1001_0104;
  localparam int          DEF_TIMEOUT_CYCLES = 15;

  // Wide enough for any timeout in 1..255
  localparam int TMO_W = 8;

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - data-RAM request/acknowledge bus
interface load_store_unit_if #(
  parameter int ADDR_W = 6
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/load_store_unit_port_in_sync.sv
// rtl/load_store_unit_port_in_sync.sv - two-flop synchroniser for the asynchronous PortIn pins
module load_store_unit_port_in_sync #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  // First flop may go metastable; second gives it a full cycle to settle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;
endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - MIPS data-memory stage: RAM handshake, PortOut/PortIn registers, error flags
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter logic [31:0] DATA_BASE      = DEF_DATA_BASE,
  parameter int          DATA_DEPTH     = DEF_DATA_DEPTH,
  parameter logic [31:0] PORT_OUT_ADDR  = DEF_PORT_OUT_ADDR,
  parameter logic [31:0] PORT_IN_ADDR   = DEF_PORT_IN_ADDR,
  parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [31:0]       Address,
  input  logic [31:0]       WriteData,
  output logic [31:0]       ReadData,
  output logic              Stall,
  input  logic [7:0]        PortIn,
  output logic [31:0]       PortOut,
  load_store_unit_if.master mem,
  output logic              MisalignedError,
  output logic              BusError
);
  localparam int             AW       = $clog2(DATA_DEPTH);
  localparam logic [31:0]    RAM_END  = DATA_BASE + 32'(4 * DATA_DEPTH);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  lsu_state_t       r_state;
  lsu_state_t       w_state_nxt;
  logic             r_mem_req;
  logic             r_mem_we;
  logic [AW-1:0]    r_mem_addr;
  logic [31:0]      r_mem_wdata;
  logic             r_is_load;
  logic [31:0]      r_load_data;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic [31:0]      r_port_out;
  logic             r_mis_err;
  logic             r_bus_err;

  logic [7:0]       w_port_in_sync;
  logic [31:0]      w_offset;
  logic [AW-1:0]    w_word_idx;
  logic             w_aligned, w_ram_hit, w_io_out, w_io_in, w_access, w_idle;
  logic             w_ram_go, w_misalign, w_unmapped, w_port_wr, w_timeout;

  load_store_unit_port_in_sync #(.W(8)) u_port_in_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (PortIn),
    .o_q   (w_port_in_sync)
  );

  // Address decode; only acted on in IDLE so inputs may wander while stalled
  assign w_aligned  = (Address[1:0] == 2'b00);
  assign w_ram_hit  = (Address >= DATA_BASE) && (Address < RAM_END);
  assign w_io_out   = (Address == PORT_OUT_ADDR);
  assign w_io_in    = (Address == PORT_IN_ADDR);
  assign w_access   = MemRead | MemWrite;
  assign w_idle     = (r_state == ST_IDLE);
  assign w_offset   = Address - DATA_BASE;
  assign w_word_idx = AW'(w_offset >> 2);

  // Misalignment takes precedence over the map check; gating with reset keeps Stall low while held in reset
  assign w_ram_go   = w_idle & ~reset & w_access & w_aligned & w_ram_hit;
  assign w_misalign = w_idle & w_access & ~w_aligned;
  assign w_unmapped = w_idle & w_access & w_aligned & ~w_ram_hit & ~w_io_out & ~w_io_in;
  assign w_port_wr  = w_idle & MemWrite & w_aligned & w_io_out;
  assign w_timeout  = (r_state == ST_WAIT) & ~mem.mem_ack & (r_tmo_cnt == TMO_LAST);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_ram_go) w_state_nxt = ST_WAIT;
      ST_WAIT: if (mem.mem_ack || w_timeout) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: Stall and the load result seen by the register file
  always_comb begin
    Stall    = 1'b0;
    ReadData = '0;
    case (r_state)
      ST_IDLE: begin
        Stall = w_ram_go;
        if (MemRead && !MemWrite && w_aligned) begin
          if (w_io_in)       ReadData = {24'b0, w_port_in_sync};
          else if (w_io_out) ReadData = r_port_out;
        end
      end
      ST_WAIT: Stall = 1'b1;
      ST_DONE: ReadData = r_is_load ? r_load_data : 32'b0;
      default: ;
    endcase
  end

  // RAM transaction registers: latched once in IDLE, request held for the whole WAIT phase
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_is_load   <= 1'b0;
      r_tmo_cnt   <= '0;
    end else begin
      r_mem_req <= (w_state_nxt == ST_WAIT);
      if (w_ram_go) begin
        r_mem_addr  <= w_word_idx;
        r_mem_wdata <= WriteData;
        r_mem_we    <= MemWrite;
        r_is_load   <= ~MemWrite;
        r_tmo_cnt   <= '0;
      end else if (r_state == ST_WAIT) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
    end
  end

  // Load register: RAM data on ack, zero on timeout
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_load_data <= '0;
    end else if (r_state == ST_WAIT) begin
      if (mem.mem_ack) begin
        if (r_is_load) r_load_data <= mem.mem_rdata;
      end else if (w_timeout) begin
        r_load_data <= '0;
      end
    end
  end

  // PortOut register and sticky error flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_port_out <= '0;
      r_mis_err  <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      if (w_port_wr)              r_port_out <= WriteData;
      if (w_misalign)             r_mis_err  <= 1'b1;
      if (w_unmapped | w_timeout) r_bus_err  <= 1'b1;
    end
  end

  assign mem.mem_req    = r_mem_req;
  assign mem.mem_we     = r_mem_we;
  assign mem.mem_addr   = r_mem_addr;
  assign mem.mem_wdata  = r_mem_wdata;
  assign PortOut        = r_port_out;
  assign MisalignedError = r_mis_err;
  assign BusError       = r_bus_err;
endmodule
